board_writer: RTL and testbench

Sole write port of the 64-square board register. Loads the standard opening position after reset, then commits moves requested by game logic as two sequenced square writes with a four-phase handshake. It runs on full_clock, so it synchronizes requests that arrive from the slower game-logic clock domain. Its write outputs drive the board register; the VGA path reads that register.

---
 rtl/chess_pkg.sv | 60 ++++++
 rtl/board_writer_if.sv | 28 ++
 rtl/req_sync.sv | 19 +
 rtl/board_writer.sv | 136 +++++++++++++
 tb/tb_board_writer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// Shared chess definitions: piece/color codes, square helpers, opening layout, writer state encoding.
// Pure declarations; no clocked logic and no handshake of its own.
package chess_pkg;

    localparam logic [2:0] PIECE_NONE   = 3'd0;
    localparam logic [2:0] PIECE_PAWN   = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT = 3'd2;
    localparam logic [2:0] PIECE_BISHOP = 3'd3;
    localparam logic [2:0] PIECE_ROOK   = 3'd4;
    localparam logic [2:0] PIECE_QUEEN  = 3'd5;
    localparam logic [2:0] PIECE_KING   = 3'd6;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    localparam logic [5:0] LAST_SQUARE = 6'd63;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_WDST,
        ST_WSRC,
        ST_ACK
    } state_t;

    function automatic logic [2:0] sq_row(input logic [5:0] sq);
        return sq[5:3];
    endfunction

    function automatic logic [2:0] sq_col(input logic [5:0] sq);
        return sq[2:0];
    endfunction

    function automatic logic [3:0] board_square(input logic [255:0] board, input logic [5:0] sq);
        return board[{sq, 2'b00} +: 4];
    endfunction

    // Row 0 is black's back rank, row 7 is white's.
    function automatic logic [3:0] init_piece(input logic [5:0] sq);
        logic [2:0] back;
        logic [3:0] pc;
        case (sq_col(sq))
            3'd0, 3'd7: back = PIECE_ROOK;
            3'd1, 3'd6: back = PIECE_KNIGHT;
            3'd2, 3'd5: back = PIECE_BISHOP;
            3'd3:       back = PIECE_QUEEN;
            default:    back = PIECE_KING;
        endcase
        case (sq_row(sq))
            3'd0:    pc = {COLOR_BLACK, back};
            3'd1:    pc = {COLOR_BLACK, PIECE_PAWN};
            3'd6:    pc = {COLOR_WHITE, PIECE_PAWN};
            3'd7:    pc = {COLOR_WHITE, back};
            default: pc = {COLOR_WHITE, PIECE_NONE};
        endcase
        return pc;
    endfunction

endpackage

// File: rtl/board_writer_if.sv
// Move request/ack handshake plus board read/write bus between game logic, board register and writer.
// The writer side is the slave; requester and board register together form the master side.
interface board_writer_if;
    logic [255:0] board_input;
    logic         move_req;
    logic [5:0]   move_from;
    logic [5:0]   move_to;
    logic         move_ack;
    logic         move_err;
    logic [3:0]   captured_piece;
    logic         busy;
    logic         init_done;
    logic [5:0]   board_out_addr;
    logic [3:0]   board_out_piece;
    logic         board_change_enable;

    modport master (
        output board_input, move_req, move_from, move_to,
        input  move_ack, move_err, captured_piece, busy, init_done,
               board_out_addr, board_out_piece, board_change_enable
    );

    modport slave (
        input  board_input, move_req, move_from, move_to,
        output move_ack, move_err, captured_piece, busy, init_done,
               board_out_addr, board_out_piece, board_change_enable
    );
endinterface

// File: rtl/req_sync.sv
// Multi-flop synchronizer for the game-logic move request; asynchronous clear to 0.
// Latency STAGES full_clock edges; no backpressure.
module req_sync #(
    parameter int STAGES = 2
) (
    input  logic full_clock,
    input  logic Reset,
    input  logic level,
    output logic synced
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge full_clock or posedge Reset) begin
        if (Reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], level};
    end

    assign synced = chain[STAGES-1];
endmodule

// File: rtl/board_writer.sv
// Sole board write port: opening-position sweep after reset, then two-write moves under a 4-phase req/ack.
// Move ack SYNC_STAGES+3 edges after req (SYNC_STAGES+1 if rejected); optional pawn promotion via MOVE_PROMOTE_EN.
module board_writer
    import chess_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input logic          full_clock,
    input logic          Reset,
    board_writer_if.slave bus
);
    state_t     state;
    logic       req_s;
    logic [5:0] sweep_addr;
    logic [5:0] from_sq;
    logic [3:0] dst_held;

    logic       ack_q, err_q, busy_q, done_q, en_q;
    logic [3:0] cap_q, piece_q;
    logic [5:0] addr_q;

    logic [3:0] src_pc, dst_pc, land_pc;
    logic       reject;

    req_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .full_clock (full_clock),
        .Reset      (Reset),
        .level      (bus.move_req),
        .synced     (req_s)
    );

    assign src_pc = board_square(bus.board_input, bus.move_from);
    assign dst_pc = board_square(bus.board_input, bus.move_to);
    assign reject = (bus.move_from == bus.move_to)
                 || (src_pc[2:0] == PIECE_NONE)
                 || ((dst_pc[2:0] != PIECE_NONE) && (dst_pc[3] == src_pc[3]));

`ifdef MOVE_PROMOTE_EN
    always_comb begin
        land_pc = src_pc;
        if (src_pc[2:0] == PIECE_PAWN &&
            ((src_pc[3] == COLOR_WHITE && sq_row(bus.move_to) == 3'd0) ||
             (src_pc[3] == COLOR_BLACK && sq_row(bus.move_to) == 3'd7)))
            land_pc = {src_pc[3], PIECE_QUEEN};
    end
`else
    assign land_pc = src_pc;
`endif

    always_ff @(posedge full_clock or posedge Reset) begin
        if (Reset) begin
            state      <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
            sweep_addr <= '0;
            from_sq    <= '0;
            dst_held   <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            cap_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= !INIT_ON_RESET;
            addr_q     <= '0;
            piece_q    <= '0;
            en_q       <= 1'b0;
        end else begin
            en_q <= 1'b0;
            case (state)
                ST_INIT: begin
                    addr_q     <= sweep_addr;
                    piece_q    <= init_piece(sweep_addr);
                    en_q       <= 1'b1;
                    busy_q     <= 1'b1;
                    sweep_addr <= sweep_addr + 6'd1;
                    if (sweep_addr == LAST_SQUARE) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    ack_q  <= 1'b0;
                    err_q  <= 1'b0;
                    cap_q  <= '0;
                    done_q <= 1'b1;
                    // Gating on done_q holds off a request raised during the sweep for one more cycle.
                    if (req_s && done_q) begin
                        state  <= ST_READ;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_READ: begin
                    from_sq  <= bus.move_from;
                    dst_held <= dst_pc;
                    if (reject) begin
                        state <= ST_ACK;
                        ack_q <= 1'b1;
                        err_q <= 1'b1;
                        cap_q <= '0;
                    end else begin
                        state   <= ST_WDST;
                        addr_q  <= bus.move_to;
                        piece_q <= land_pc;
                        en_q    <= 1'b1;
                    end
                end
                ST_WDST: begin
                    state   <= ST_WSRC;
                    addr_q  <= from_sq;
                    piece_q <= {COLOR_WHITE, PIECE_NONE};
                    en_q    <= 1'b1;
                end
                ST_WSRC: begin
                    state <= ST_ACK;
                    ack_q <= 1'b1;
                    err_q <= 1'b0;
                    cap_q <= dst_held;
                end
                ST_ACK: begin
                    // ack itself drops on the following IDLE cycle.
                    if (!req_s) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.move_ack            = ack_q;
    assign bus.move_err            = err_q;
    assign bus.captured_piece      = cap_q;
    assign bus.busy                = busy_q;
    assign bus.init_done           = done_q;
    assign bus.board_out_addr      = addr_q;
    assign bus.board_out_piece     = piece_q;
    assign bus.board_change_enable = en_q;
endmodule

// File: tb/tb_board_writer.sv
// Self-checking bench for board_writer: opening sweep, directed move table, random moves vs. a rules model, reset corners.
module tb_board_writer;
    localparam int S = 2;

    logic full_clock = 1'b0;
    logic Reset;
    always #5 full_clock = ~full_clock;

    board_writer_if bus();

    board_writer #(.SYNC_STAGES(S), .INIT_ON_RESET(1'b1)) dut (
        .full_clock (full_clock),
        .Reset      (Reset),
        .bus        (bus)
    );

    // External board register fed by the writer and read back through board_input.
    logic [3:0] board_reg [64];
    always @(posedge full_clock)
        if (bus.board_change_enable) board_reg[bus.board_out_addr] <= bus.board_out_piece;
    for (genvar g = 0; g < 64; g++) begin : g_board
        assign bus.board_input[4*g +: 4] = board_reg[g];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] ref_board [64];

    function automatic logic [3:0] ref_init(input int sq);
        int back[8];
        int row, col;
        back = '{4, 2, 3, 5, 6, 3, 2, 4};
        row  = sq / 8;
        col  = sq % 8;
        if (row == 0) return 4'(8 + back[col]);
        if (row == 1) return 4'd9;
        if (row == 6) return 4'd1;
        if (row == 7) return 4'(back[col]);
        return 4'd0;
    endfunction

    function automatic void ref_move(input int f, input int t, output bit err,
                                     output logic [3:0] cap, output logic [3:0] land);
        logic [3:0] s, d;
        s    = ref_board[f];
        d    = ref_board[t];
        err  = (f == t) || (s[2:0] == 3'd0) || (d[2:0] != 3'd0 && d[3] == s[3]);
        cap  = err ? 4'd0 : d;
        land = s;
`ifdef MOVE_PROMOTE_EN
        if (s[2:0] == 3'd1 && ((s[3] == 1'b0 && t / 8 == 0) || (s[3] == 1'b1 && t / 8 == 7)))
            land = {s[3], 3'd5};
`endif
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 64; i++) ref_board[i] = ref_init(i);
    endtask

    task automatic check_board(input string tag);
        int mism = 0;
        for (int i = 0; i < 64; i++) if (board_reg[i] !== ref_board[i]) mism++;
        chk({tag, " board mismatches"}, 32'(mism), 32'd0);
    endtask

    // Reset must already be released at a negedge; checks edges 1..65.
    task automatic check_sweep(input string tag);
        for (int k = 1; k <= 64; k++) begin
            @(posedge full_clock); #1;
            chk({tag, " sweep en"},   32'(bus.board_change_enable), 32'd1);
            chk({tag, " sweep addr"}, 32'(bus.board_out_addr), 32'(k - 1));
            chk({tag, " sweep data"}, 32'(bus.board_out_piece), 32'(ref_init(k - 1)));
            case (k - 1)
                0:  chk({tag, " sq0 rook"},   32'(bus.board_out_piece), 32'b1100);
                4:  chk({tag, " sq4 king"},   32'(bus.board_out_piece), 32'b1110);
                12: chk({tag, " sq12 pawn"},  32'(bus.board_out_piece), 32'b1001);
                20: chk({tag, " sq20 empty"}, 32'(bus.board_out_piece), 32'b0000);
                59: chk({tag, " sq59 queen"}, 32'(bus.board_out_piece), 32'b0101);
                63: chk({tag, " sq63 rook"},  32'(bus.board_out_piece), 32'b0100);
                default: ;
            endcase
            if (k == 64) chk({tag, " init_done before 65"}, 32'(bus.init_done), 32'd0);
        end
        @(posedge full_clock); #1;
        chk({tag, " edge65 en"},        32'(bus.board_change_enable), 32'd0);
        chk({tag, " edge65 init_done"}, 32'(bus.init_done), 32'd1);
        chk({tag, " edge65 busy"},      32'(bus.busy), 32'd0);
    endtask

    task automatic release_req(input string tag);
        logic [15:0] ack_s, en_s;
        ack_s = '0;
        en_s  = '0;
        @(negedge full_clock);
        bus.move_req = 1'b0;
        for (int e = 0; e <= S + 3; e++) begin
            @(posedge full_clock); #1;
            ack_s[e] = bus.move_ack;
            en_s[e]  = bus.board_change_enable;
        end
        chk({tag, " ack held through sync"}, 32'(ack_s[S-1]), 32'd1);
        chk({tag, " ack fell"},              32'(ack_s[S+1]), 32'd0);
        chk({tag, " no strobe on release"},  32'(en_s), 32'd0);
        chk({tag, " idle busy"},             32'(bus.busy), 32'd0);
    endtask

    task automatic run_move(input int f, input int t, input bit exp_err,
                            input logic [3:0] exp_cap, input logic [3:0] exp_land, input string tag);
        logic [15:0] en_s, ack_s, busy_s, exp_en, exp_ack;
        logic [5:0]  ad_s [16];
        logic [3:0]  pc_s [16];
        int ack_edge;
        en_s = '0; ack_s = '0; busy_s = '0; exp_en = '0; exp_ack = '0;
        @(negedge full_clock);
        bus.move_from = 6'(f);
        bus.move_to   = 6'(t);
        bus.move_req  = 1'b1;
        for (int e = 0; e <= S + 5; e++) begin
            @(posedge full_clock); #1;
            en_s[e]   = bus.board_change_enable;
            ack_s[e]  = bus.move_ack;
            busy_s[e] = bus.busy;
            ad_s[e]   = bus.board_out_addr;
            pc_s[e]   = bus.board_out_piece;
        end
        ack_edge = exp_err ? S + 1 : S + 3;
        for (int e = 0; e <= S + 5; e++) begin
            exp_en[e]  = !exp_err && (e == S + 1 || e == S + 2);
            exp_ack[e] = (e >= ack_edge);
        end
        chk({tag, " busy before READ"}, 32'(busy_s[S-1]), 32'd0);
        chk({tag, " busy at READ"},     32'(busy_s[S]), 32'd1);
        chk({tag, " strobe pattern"},   32'(en_s), 32'(exp_en));
        chk({tag, " ack pattern"},      32'(ack_s), 32'(exp_ack));
        if (!exp_err) begin
            chk({tag, " wdst addr"}, 32'(ad_s[S+1]), 32'(t));
            chk({tag, " wdst data"}, 32'(pc_s[S+1]), 32'(exp_land));
            chk({tag, " wsrc addr"}, 32'(ad_s[S+2]), 32'(f));
            chk({tag, " wsrc data"}, 32'(pc_s[S+2]), 32'd0);
            ref_board[t] = exp_land;
            ref_board[f] = 4'd0;
        end
        chk({tag, " move_err"},       32'(bus.move_err), 32'(exp_err));
        chk({tag, " captured_piece"}, 32'(bus.captured_piece), 32'(exp_cap));
        release_req(tag);
    endtask

    typedef struct {
        int         f;
        int         t;
        bit         err;
        logic [3:0] cap;
        logic [3:0] land;
    } vec_t;

    localparam logic [3:0] PROMO_LAND =
`ifdef MOVE_PROMOTE_EN
        4'b0101;
`else
        4'b0001;
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        bit          r_err;
        logic [3:0]  r_cap, r_land;
        int          f, t, tries, lf, lt;
        logic [15:0] en_s;
        int          ack_at, strobes;
        logic [5:0]  st_addr [4];
        logic [3:0]  st_data [4];

        vt[0] = '{52, 36, 1'b0, 4'b0000, 4'b0001};
        vt[1] = '{61,  1, 1'b0, 4'b1010, 4'b0011};
        vt[2] = '{59, 60, 1'b1, 4'b0000, 4'b0000};
        vt[3] = '{10, 10, 1'b1, 4'b0000, 4'b0000};
        vt[4] = '{30, 20, 1'b1, 4'b0000, 4'b0000};
        vt[5] = '{48,  8, 1'b0, 4'b1001, 4'b0001};
        vt[6] = '{ 8,  0, 1'b0, 4'b1100, PROMO_LAND};

        for (int i = 0; i < 64; i++) board_reg[i] = 4'd0;
        Reset         = 1'b1;
        bus.move_req  = 1'b0;
        bus.move_from = 6'd0;
        bus.move_to   = 6'd0;

        repeat (3) @(posedge full_clock);
        #1;
        chk("reset en",        32'(bus.board_change_enable), 32'd0);
        chk("reset addr",      32'(bus.board_out_addr), 32'd0);
        chk("reset piece",     32'(bus.board_out_piece), 32'd0);
        chk("reset ack",       32'(bus.move_ack), 32'd0);
        chk("reset err",       32'(bus.move_err), 32'd0);
        chk("reset captured",  32'(bus.captured_piece), 32'd0);
        chk("reset busy",      32'(bus.busy), 32'd0);
        chk("reset init_done", 32'(bus.init_done), 32'd0);

        @(negedge full_clock);
        Reset = 1'b0;
        check_sweep("boot");
        ref_reset();
        check_board("after boot");

        for (int i = 0; i < 7; i++)
            run_move(vt[i].f, vt[i].t, vt[i].err, vt[i].cap, vt[i].land, $sformatf("vec%0d", i));
        check_board("after directed");

        for (int n = 0; n < 40; n++) begin
            f = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) begin
                tries = 0;
                while (ref_board[f][2:0] == 3'd0 && tries < 64) begin
                    f = $urandom_range(0, 63);
                    tries++;
                end
            end
            t = ($urandom_range(0, 9) == 0) ? f : $urandom_range(0, 63);
            ref_move(f, t, r_err, r_cap, r_land);
            run_move(f, t, r_err, r_cap, r_land, $sformatf("rnd%0d", n));
        end
        check_board("after random");

        // Reset during the WDST write, then a request raised while the sweep runs.
        lf = -1; lt = -1;
        for (int a = 0; a < 64 && lf < 0; a++)
            for (int b = 0; b < 64 && lf < 0; b++) begin
                ref_move(a, b, r_err, r_cap, r_land);
                if (!r_err) begin lf = a; lt = b; end
            end
        if (lf < 0) begin lf = 52; lt = 36; end
        @(negedge full_clock);
        bus.move_from = 6'(lf);
        bus.move_to   = 6'(lt);
        bus.move_req  = 1'b1;
        repeat (S + 2) @(posedge full_clock);
        #1;
        chk("midmove wdst strobe", 32'(bus.board_change_enable), 32'd1);
        chk("midmove wdst addr",   32'(bus.board_out_addr), 32'(lt));
        #2 Reset = 1'b1;
        #1;
        chk("midmove reset en",   32'(bus.board_change_enable), 32'd0);
        chk("midmove reset busy", 32'(bus.busy), 32'd0);
        chk("midmove reset done", 32'(bus.init_done), 32'd0);
        bus.move_req = 1'b0;
        repeat (2) @(posedge full_clock);
        @(negedge full_clock);
        Reset         = 1'b0;
        bus.move_from = 6'd52;
        bus.move_to   = 6'd36;
        bus.move_req  = 1'b1;
        check_sweep("rearm");
        ref_reset();

        strobes = 0;
        ack_at  = -1;
        en_s    = '0;
        for (int e = 0; e < 12 && ack_at < 0; e++) begin
            @(posedge full_clock); #1;
            en_s[e] = bus.board_change_enable;
            if (bus.board_change_enable && strobes < 4) begin
                st_addr[strobes] = bus.board_out_addr;
                st_data[strobes] = bus.board_out_piece;
                strobes++;
            end
            if (bus.move_ack) ack_at = e;
        end
        chk("held req ack seen",    32'(ack_at >= 0), 32'd1);
        chk("held req strobe count", 32'(strobes), 32'd2);
        if (strobes == 2) begin
            chk("held req wdst addr", 32'(st_addr[0]), 32'd36);
            chk("held req wdst data", 32'(st_data[0]), 32'b0001);
            chk("held req wsrc addr", 32'(st_addr[1]), 32'd52);
            chk("held req wsrc data", 32'(st_data[1]), 32'b0000);
        end
        chk("held req move_err", 32'(bus.move_err), 32'd0);
        chk("held req captured", 32'(bus.captured_piece), 32'd0);
        release_req("held req");
        ref_board[36] = 4'b0001;
        ref_board[52] = 4'b0000;
        check_board("after rearm");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
